fft_input_frame_loader: RTL and testbench

- Captures a serial stream of real ADC samples into a 32-point frame buffer, writing each sample at its bit-reversed address.
- The FFT butterfly stages then read the frame in natural address order and receive it already in bit-reversed order.
- Two banks (ping-pong): capture of frame n+1 overlaps FFT consumption of frame n.
- Sits between the ADC sample interface and the first radix-2 butterfly stage; replaces the static combinational reordering of 32 parallel inputs.

---
 rtl/fft_input_frame_loader_if.sv | 37 +++
 rtl/fft_input_frame_loader.sv | 85 ++++++++
 tb/tb_fft_input_frame_loader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_input_frame_loader_if.sv
// Sample-in / frame-out bus of the FFT input frame loader.
// It also carries read-only debug views of the loader's write-side state.
interface fft_input_frame_loader_if #(
  parameter int ADC_bits = 8,
  parameter int ADDR_W   = 5
);
  // Handshake rules:
  // - A sample transfers on a rising edge where in_valid && in_ready.
  // - The source may raise in_valid at any time, and must hold in_data until the transfer.
  // - rd_data answers an rd_en one cycle later.
  // - frame_done releases rd_bank only while frame_valid is high.
  logic                in_valid;
  logic                in_ready;
  logic [ADC_bits-1:0] in_data;
  logic                frame_valid;
  logic                rd_bank;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADC_bits-1:0] rd_data;
  logic                frame_done;
  logic [15:0]         frame_cnt;
  logic [ADDR_W-1:0]   dbg_wr_cnt;
  logic                dbg_wr_bank;
  logic [1:0]          dbg_full;

  modport master (
    output in_valid, in_data, rd_en, rd_addr, frame_done,
    input  in_ready, frame_valid, rd_bank, rd_data, frame_cnt,
    input  dbg_wr_cnt, dbg_wr_bank, dbg_full
  );

  modport slave (
    input  in_valid, in_data, rd_en, rd_addr, frame_done,
    output in_ready, frame_valid, rd_bank, rd_data, frame_cnt,
    output dbg_wr_cnt, dbg_wr_bank, dbg_full
  );
endinterface

// File: rtl/fft_input_frame_loader.sv
// Ping-pong 32-point frame buffer: samples are written at bit-reversed addresses,
// so the FFT reads each frame in natural order and receives it already reordered.
module fft_input_frame_loader #(
  parameter int ADC_bits = 8,
  parameter int N_POINTS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   soft_clr,
  fft_input_frame_loader_if.slave bus
);

  logic [ADC_bits-1:0] mem [2][N_POINTS];

  logic [ADDR_W-1:0]   wr_cnt;
  logic                wr_bank;
  logic                rd_bank;
  logic [1:0]          full;
  logic [ADC_bits-1:0] rd_data;
  logic [15:0]         frame_cnt;

  logic                accept;
  logic                wr_last;
  logic                rel_bank;
  logic [1:0]          full_nxt;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  assign bus.in_ready    = ~full[wr_bank];
  assign bus.frame_valid = full[rd_bank];
  assign bus.rd_bank     = rd_bank;
  assign bus.rd_data     = rd_data;
  assign bus.frame_cnt   = frame_cnt;
  assign bus.dbg_wr_cnt  = wr_cnt;
  assign bus.dbg_wr_bank = wr_bank;
  assign bus.dbg_full    = full;

  // Completion and release always hit different banks, so both edits can land together.
  always_comb begin
    accept   = bus.in_valid & ~full[wr_bank] & ~soft_clr;
    wr_last  = accept && (wr_cnt == ADDR_W'(N_POINTS - 1));
    rel_bank = bus.frame_done & full[rd_bank] & ~soft_clr;
    full_nxt = full;
    if (wr_last)  full_nxt[wr_bank] = 1'b1;
    if (rel_bank) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      rd_data   <= '0;
      frame_cnt <= '0;
    end else if (soft_clr) begin
      wr_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= 2'b00;
      rd_data   <= '0;
      frame_cnt <= '0;
    end else begin
      if (accept)   wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (wr_last) begin
        wr_bank   <= ~wr_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (rel_bank) rd_bank <= ~rd_bank;
      full <= full_nxt;
      if (bus.rd_en) rd_data <= mem[rd_bank][bus.rd_addr];
    end
  end

  // Sample storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_bank][bitrev(wr_cnt)] <= bus.in_data;
  end

endmodule

// File: tb/tb_fft_input_frame_loader.sv
// Self-checking bench for fft_input_frame_loader: table-driven readout vectors plus
// hand-written sequences for backpressure, ping-pong, simultaneous events and clears.
module tb_fft_input_frame_loader;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic soft_clr = 1'b0;

  always #5 clk = ~clk;

  fft_input_frame_loader_if #(.ADC_bits(8), .ADDR_W(5)) bus ();

  fft_input_frame_loader #(.ADC_bits(8), .N_POINTS(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_clr (soft_clr),
    .bus      (bus)
  );

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
  } rd_vec_t;

  rd_vec_t    ramp_tbl[8];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
    bus.frame_done = 1'b0;
    soft_clr       = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge right after the sample was accepted.
  task automatic push_sample(input logic [7:0] d);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (bus.in_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic stream(input int base, input int count, input bit hold);
    for (int i = 0; i < count; i++) push_sample(8'(base + i));
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic frame_done_pulse();
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.frame_done = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [7:0] exp, input string name);
    logic [7:0] e;
    exp_q.push_back(exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(name, 32'(bus.rd_data), 32'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ramp_tbl[0] = '{addr: 5'd0,  data: 8'd0};
    ramp_tbl[1] = '{addr: 5'd1,  data: 8'd16};
    ramp_tbl[2] = '{addr: 5'd2,  data: 8'd8};
    ramp_tbl[3] = '{addr: 5'd3,  data: 8'd24};
    ramp_tbl[4] = '{addr: 5'd16, data: 8'd1};
    ramp_tbl[5] = '{addr: 5'd31, data: 8'd31};
    ramp_tbl[6] = '{addr: 5'd5,  data: 8'd20};
    ramp_tbl[7] = '{addr: 5'd30, data: 8'd15};

    // Reset state and single ramp frame
    do_reset();
    check("rst_in_ready",    32'(bus.in_ready),    32'd1);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_rd_bank",     32'(bus.rd_bank),     32'd0);
    check("rst_rd_data",     32'(bus.rd_data),     32'd0);
    check("rst_frame_cnt",   32'(bus.frame_cnt),   32'd0);
    check("rst_full",        32'(bus.dbg_full),    32'd0);
    stream(0, 31, 1'b1);
    check("ramp_fv_before_last", 32'(bus.frame_valid), 32'd0);
    push_sample(8'd31);
    bus.in_valid = 1'b0;
    check("ramp_fv_after_last", 32'(bus.frame_valid), 32'd1);
    check("ramp_frame_cnt",     32'(bus.frame_cnt),   32'd1);
    for (int i = 0; i < 8; i++) do_read(ramp_tbl[i].addr, ramp_tbl[i].data, "ramp_read");
    bus.rd_addr = 5'd0;
    repeat (2) @(negedge clk);
    check("rd_data_hold", 32'(bus.rd_data), 32'd15);

    // Backpressure: 65th sample waits until bank 0 is released
    do_reset();
    stream(0, 64, 1'b1);
    bus.in_data = 8'd200;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_still_stalled", 32'(bus.in_ready),   32'd0);
    check("bp_wr_cnt_held",   32'(bus.dbg_wr_cnt), 32'd0);
    check("bp_frame_cnt",     32'(bus.frame_cnt),  32'd2);
    frame_done_pulse();
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    check("bp_rd_bank",       32'(bus.rd_bank),  32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_65th_accepted", 32'(bus.dbg_wr_cnt), 32'd1);
    stream(201, 31, 1'b0);
    check("bp_full_both", 32'(bus.dbg_full), 32'd3);
    frame_done_pulse();
    check("bp_rd_bank_0", 32'(bus.rd_bank), 32'd0);
    do_read(5'd0,  8'd200, "bp_65th_addr0");
    do_read(5'd16, 8'd201, "bp_66th_addr16");

    // Ping-pong
    do_reset();
    stream(0, 32, 1'b1);
    stream(100, 32, 1'b0);
    check("pp_fv",      32'(bus.frame_valid), 32'd1);
    do_read(5'd0, 8'd0, "pp_a_addr0");
    frame_done_pulse();
    check("pp_fv_stays", 32'(bus.frame_valid), 32'd1);
    check("pp_rd_bank1", 32'(bus.rd_bank),     32'd1);
    do_read(5'd0, 8'd100, "pp_b_addr0");
    do_read(5'd1, 8'd116, "pp_b_addr1");
    frame_done_pulse();
    check("pp_fv_drop", 32'(bus.frame_valid), 32'd0);

    // Spurious release with nothing presented
    frame_done_pulse();
    check("spur_rd_bank",  32'(bus.rd_bank),  32'd0);
    check("spur_full",     32'(bus.dbg_full), 32'd0);
    check("spur_in_ready", 32'(bus.in_ready), 32'd1);

    // Frame completion and release in the same cycle
    do_reset();
    stream(0, 32, 1'b0);
    stream(150, 31, 1'b1);
    bus.in_data    = 8'd181;
    bus.frame_done = 1'b1;
    @(negedge clk);
    bus.frame_done = 1'b0;
    bus.in_valid   = 1'b0;
    check("sim_full",      32'(bus.dbg_full),    32'd2);
    check("sim_rd_bank",   32'(bus.rd_bank),     32'd1);
    check("sim_wr_bank",   32'(bus.dbg_wr_bank), 32'd0);
    check("sim_fv",        32'(bus.frame_valid), 32'd1);
    check("sim_frame_cnt", 32'(bus.frame_cnt),   32'd2);
    do_read(5'd0, 8'd150, "sim_addr0");
    do_read(5'd1, 8'd166, "sim_addr1");

    // Asynchronous reset mid-frame
    do_reset();
    stream(0, 32, 1'b0);
    stream(70, 10, 1'b0);
    check("ar_wr_cnt_mid", 32'(bus.dbg_wr_cnt), 32'd10);
    do_read(5'd1, 8'd16, "ar_pre_read");
    #2 rst_n = 1'b0;
    #1;
    check("ar_fv_now",      32'(bus.frame_valid), 32'd0);
    check("ar_cnt_now",     32'(bus.frame_cnt),   32'd0);
    check("ar_rd_data_now", 32'(bus.rd_data),     32'd0);
    check("ar_wr_cnt_now",  32'(bus.dbg_wr_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream(50, 31, 1'b1);
    check("ar_fv_31", 32'(bus.frame_valid), 32'd0);
    push_sample(8'd81);
    bus.in_valid = 1'b0;
    check("ar_fv_32",  32'(bus.frame_valid), 32'd1);
    check("ar_cnt_32", 32'(bus.frame_cnt),   32'd1);
    do_read(5'd0,  8'd50, "ar_addr0");
    do_read(5'd31, 8'd81, "ar_addr31");

    // Soft clear mid-frame, colliding with accept, release and read
    do_reset();
    stream(0, 32, 1'b0);
    stream(70, 10, 1'b0);
    do_read(5'd1, 8'd16, "sc_pre_read");
    soft_clr       = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 8'd99;
    bus.frame_done = 1'b1;
    bus.rd_en      = 1'b1;
    bus.rd_addr    = 5'd0;
    @(negedge clk);
    soft_clr       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.frame_done = 1'b0;
    bus.rd_en      = 1'b0;
    check("sc_fv",       32'(bus.frame_valid), 32'd0);
    check("sc_cnt",      32'(bus.frame_cnt),   32'd0);
    check("sc_rd_data",  32'(bus.rd_data),     32'd0);
    check("sc_wr_cnt",   32'(bus.dbg_wr_cnt),  32'd0);
    check("sc_rd_bank",  32'(bus.rd_bank),     32'd0);
    check("sc_full",     32'(bus.dbg_full),    32'd0);
    check("sc_in_ready", 32'(bus.in_ready),    32'd1);
    stream(60, 31, 1'b1);
    check("sc_fv_31", 32'(bus.frame_valid), 32'd0);
    push_sample(8'd91);
    bus.in_valid = 1'b0;
    check("sc_fv_32", 32'(bus.frame_valid), 32'd1);
    do_read(5'd0, 8'd60, "sc_addr0");
    do_read(5'd1, 8'd76, "sc_addr1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
